// File: rtl/riscv_pkg.sv
// Shared types for the ID/EX pipeline slice: decoded control bundle and datapath defaults.
package riscv_pkg;

   localparam int XLEN       = 32;
   localparam int REG_ADDR_W = 5;

   typedef struct packed {
      logic       reg_write;
      logic       mem_read;
      logic       mem_write;
      logic       mem_to_reg;
      logic       alu_src;
      logic       branch;
      logic       jump;
      logic [3:0] alu_op;
   } ctrl_t;

   localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/id_ex_stage_hazard.sv
// Load-use hazard compare: the load in EX writes a register that the instruction in ID reads.
module hazard_detect #(
   parameter int REG_ADDR_W = 5
) (
   input  logic                  ex_valid_i,
   input  logic                  ex_mem_read_i,
   input  logic [REG_ADDR_W-1:0] ex_rd_i,
   input  logic                  id_valid_i,
   input  logic                  id_uses_rs1_i,
   input  logic                  id_uses_rs2_i,
   input  logic [REG_ADDR_W-1:0] id_rs1_i,
   input  logic [REG_ADDR_W-1:0] id_rs2_i,
   output logic                  hazard_o
);

   logic rs1_hit;
   logic rs2_hit;

   assign rs1_hit  = id_uses_rs1_i && (id_rs1_i == ex_rd_i);
   assign rs2_hit  = id_uses_rs2_i && (id_rs2_i == ex_rd_i);
   // x0 is hard-wired to zero, so a load into it never creates a dependency
   assign hazard_o = ex_valid_i && ex_mem_read_i && (ex_rd_i != '0) &&
                     (rs1_hit || rs2_hit) && id_valid_i;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush, front-end freeze
// and saturating stall/flush event counters.
module id_ex_stage
   import riscv_pkg::*;
#(
   parameter int XLEN       = riscv_pkg::XLEN,
   parameter int REG_ADDR_W = riscv_pkg::REG_ADDR_W,
   parameter int CNT_W      = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  id_valid,
   input  logic [XLEN-1:0]       id_pc,
   input  logic [REG_ADDR_W-1:0] id_rs1,
   input  logic [REG_ADDR_W-1:0] id_rs2,
   input  logic                  id_uses_rs1,
   input  logic                  id_uses_rs2,
   input  logic [REG_ADDR_W-1:0] id_rd,
   input  logic [XLEN-1:0]       id_rdata1,
   input  logic [XLEN-1:0]       id_rdata2,
   input  logic [XLEN-1:0]       id_imm,
   input  ctrl_t                 id_ctrl,
   input  logic                  mem_stall,
   input  logic                  ex_flush,
   output logic                  ex_valid,
   output logic [XLEN-1:0]       ex_pc,
   output logic [XLEN-1:0]       ex_imm,
   output logic [REG_ADDR_W-1:0] ex_rs1,
   output logic [REG_ADDR_W-1:0] ex_rs2,
   output logic [REG_ADDR_W-1:0] ex_rd,
   output logic [XLEN-1:0]       ex_rdata1,
   output logic [XLEN-1:0]       ex_rdata2,
   output ctrl_t                 ex_ctrl,
   output logic                  pc_write,
   output logic                  if_id_write,
   output logic                  load_use_stall,
   output logic [CNT_W-1:0]      stall_cnt,
   output logic [CNT_W-1:0]      flush_cnt
);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   logic                  valid_q,  valid_d;
   logic [XLEN-1:0]       pc_q,     pc_d;
   logic [XLEN-1:0]       imm_q,    imm_d;
   logic [REG_ADDR_W-1:0] rs1_q,    rs1_d;
   logic [REG_ADDR_W-1:0] rs2_q,    rs2_d;
   logic [REG_ADDR_W-1:0] rd_q,     rd_d;
   logic [XLEN-1:0]       rdata1_q, rdata1_d;
   logic [XLEN-1:0]       rdata2_q, rdata2_d;
   ctrl_t                 ctrl_q,   ctrl_d;
   logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0]      flush_cnt_q, flush_cnt_d;
   logic                  hazard;
   logic                  bubble;

   hazard_detect #(
      .REG_ADDR_W(REG_ADDR_W)
   ) u_hazard (
      .ex_valid_i    (valid_q),
      .ex_mem_read_i (ctrl_q.mem_read),
      .ex_rd_i       (rd_q),
      .id_valid_i    (id_valid),
      .id_uses_rs1_i (id_uses_rs1),
      .id_uses_rs2_i (id_uses_rs2),
      .id_rs1_i      (id_rs1),
      .id_rs2_i      (id_rs2),
      .hazard_o      (hazard)
   );

   always_comb begin
      pc_write       = 1'b1;
      if_id_write    = 1'b1;
      load_use_stall = 1'b0;
      bubble         = 1'b0;
      stall_cnt_d    = stall_cnt_q;
      flush_cnt_d    = flush_cnt_q;
      valid_d        = id_valid;
      pc_d           = id_pc;
      imm_d          = id_imm;
      rs1_d          = id_rs1;
      rs2_d          = id_rs2;
      rd_d           = id_rd;
      rdata1_d       = id_rdata1;
      rdata2_d       = id_rdata2;
      ctrl_d         = id_valid ? id_ctrl : CTRL_NOP;

      // mem_stall outranks flush: EX is frozen, so the branch unit re-asserts flush later
      if (mem_stall) begin
         pc_write    = 1'b0;
         if_id_write = 1'b0;
         valid_d     = valid_q;
         pc_d        = pc_q;
         imm_d       = imm_q;
         rs1_d       = rs1_q;
         rs2_d       = rs2_q;
         rd_d        = rd_q;
         rdata1_d    = rdata1_q;
         rdata2_d    = rdata2_q;
         ctrl_d      = ctrl_q;
      end else if (ex_flush) begin
         bubble      = 1'b1;
         flush_cnt_d = sat_inc(flush_cnt_q);
      end else if (hazard) begin
         bubble         = 1'b1;
         pc_write       = 1'b0;
         if_id_write    = 1'b0;
         load_use_stall = 1'b1;
         stall_cnt_d    = sat_inc(stall_cnt_q);
      end

      // Bubble zeroes indices too, so forwarding never matches a bubble's rd
      if (bubble) begin
         valid_d  = 1'b0;
         pc_d     = '0;
         imm_d    = '0;
         rs1_d    = '0;
         rs2_d    = '0;
         rd_d     = '0;
         rdata1_d = '0;
         rdata2_d = '0;
         ctrl_d   = CTRL_NOP;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q     <= 1'b0;
         pc_q        <= '0;
         imm_q       <= '0;
         rs1_q       <= '0;
         rs2_q       <= '0;
         rd_q        <= '0;
         rdata1_q    <= '0;
         rdata2_q    <= '0;
         ctrl_q      <= CTRL_NOP;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         valid_q     <= valid_d;
         pc_q        <= pc_d;
         imm_q       <= imm_d;
         rs1_q       <= rs1_d;
         rs2_q       <= rs2_d;
         rd_q        <= rd_d;
         rdata1_q    <= rdata1_d;
         rdata2_q    <= rdata2_d;
         ctrl_q      <= ctrl_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign ex_valid  = valid_q;
   assign ex_pc     = pc_q;
   assign ex_imm    = imm_q;
   assign ex_rs1    = rs1_q;
   assign ex_rs2    = rs2_q;
   assign ex_rd     = rd_q;
   assign ex_rdata1 = rdata1_q;
   assign ex_rdata2 = rdata2_q;
   assign ex_ctrl   = ctrl_q;
   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage (CNT_W=4 build so counter saturation is reachable).
module tb_id_ex_stage;
   import riscv_pkg::*;

   localparam int XW = 32;
   localparam int AW = 5;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          id_valid;
   logic [XW-1:0] id_pc, id_rdata1, id_rdata2, id_imm;
   logic [AW-1:0] id_rs1, id_rs2, id_rd;
   logic          id_uses_rs1, id_uses_rs2;
   ctrl_t         id_ctrl;
   logic          mem_stall, ex_flush;
   logic          ex_valid;
   logic [XW-1:0] ex_pc, ex_imm, ex_rdata1, ex_rdata2;
   logic [AW-1:0] ex_rs1, ex_rs2, ex_rd;
   ctrl_t         ex_ctrl;
   logic          pc_write, if_id_write, load_use_stall;
   logic [CW-1:0] stall_cnt, flush_cnt;

   int n_cmp = 0;
   int n_err = 0;
   ctrl_t c_lw, c_add;

   always #5 clk = ~clk;

   id_ex_stage #(.XLEN(XW), .REG_ADDR_W(AW), .CNT_W(CW)) dut (
      .clk(clk), .reset(reset), .id_valid(id_valid), .id_pc(id_pc),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
      .id_rd(id_rd), .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm),
      .id_ctrl(id_ctrl), .mem_stall(mem_stall), .ex_flush(ex_flush),
      .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
      .ex_rd(ex_rd), .ex_rdata1(ex_rdata1), .ex_rdata2(ex_rdata2), .ex_ctrl(ex_ctrl),
      .pc_write(pc_write), .if_id_write(if_id_write), .load_use_stall(load_use_stall),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [XW-1:0] pc,
                        input logic [AW-1:0] rs1, input logic u1,
                        input logic [AW-1:0] rs2, input logic u2,
                        input logic [AW-1:0] rd, input logic [XW-1:0] d1,
                        input logic [XW-1:0] d2, input logic [XW-1:0] imm,
                        input ctrl_t c);
      id_valid = v;   id_pc = pc;
      id_rs1 = rs1;   id_uses_rs1 = u1;
      id_rs2 = rs2;   id_uses_rs2 = u2;
      id_rd = rd;     id_rdata1 = d1;   id_rdata2 = d2;
      id_imm = imm;   id_ctrl = c;
      #1;
   endtask

   initial begin
      c_lw = CTRL_NOP;
      c_lw.reg_write = 1'b1; c_lw.mem_read = 1'b1; c_lw.mem_to_reg = 1'b1; c_lw.alu_src = 1'b1;
      c_add = CTRL_NOP;
      c_add.reg_write = 1'b1; c_add.alu_op = 4'h1;
      mem_stall = 1'b0;
      ex_flush  = 1'b0;
      reset     = 1'b1;

      // Reset for 2 cycles with a valid load presented
      drive(1, 32'h100, 5'd2, 1, 5'd0, 0, 5'd5, 32'h1000, 32'h0, 32'h8, c_lw);
      tick(); tick();
      chk("rst_ex_valid", ex_valid, 0);
      chk("rst_ex_ctrl", ex_ctrl, CTRL_NOP);
      chk("rst_ex_pc", ex_pc, 0);
      chk("rst_stall_cnt", stall_cnt, 0);
      chk("rst_flush_cnt", flush_cnt, 0);
      chk("rst_pc_write", pc_write, 1);
      chk("rst_if_id_write", if_id_write, 1);
      chk("rst_lus", load_use_stall, 0);
      reset = 1'b0;

      // lw x5 enters EX
      tick();
      chk("lw_ex_valid", ex_valid, 1);
      chk("lw_ex_rd", ex_rd, 5);
      chk("lw_ex_ctrl", ex_ctrl, c_lw);
      chk("lw_ex_pc", ex_pc, 32'h100);
      chk("lw_ex_imm", ex_imm, 32'h8);

      // add x6,x5,x1 in ID -> load-use stall
      drive(1, 32'h104, 5'd5, 1, 5'd1, 1, 5'd6, 32'hAA, 32'h11, 32'h0, c_add);
      chk("lu_stall", load_use_stall, 1);
      chk("lu_pc_write", pc_write, 0);
      chk("lu_if_id_write", if_id_write, 0);
      tick();
      chk("bub_ex_valid", ex_valid, 0);
      chk("bub_ex_ctrl", ex_ctrl, CTRL_NOP);
      chk("bub_ex_rd", ex_rd, 0);
      chk("bub_ex_rs1", ex_rs1, 0);
      chk("bub_ex_pc", ex_pc, 0);
      chk("bub_stall_cnt", stall_cnt, 1);
      chk("bub_lus", load_use_stall, 0);
      chk("bub_pc_write", pc_write, 1);
      tick();
      chk("dep_ex_valid", ex_valid, 1);
      chk("dep_ex_rs1", ex_rs1, 5);
      chk("dep_ex_rs2", ex_rs2, 1);
      chk("dep_ex_rdata1", ex_rdata1, 32'hAA);
      chk("dep_ex_rdata2", ex_rdata2, 32'h11);
      chk("dep_ex_ctrl", ex_ctrl, c_add);
      chk("dep_stall_cnt", stall_cnt, 1);

      // lw x0 then a reader of x0 -> no stall
      drive(1, 32'h108, 5'd2, 1, 5'd0, 0, 5'd0, 32'h0, 32'h0, 32'h4, c_lw);
      tick();
      drive(1, 32'h10C, 5'd0, 1, 5'd0, 1, 5'd7, 32'h0, 32'h0, 32'h0, c_add);
      chk("x0_lus", load_use_stall, 0);
      chk("x0_pc_write", pc_write, 1);
      tick();
      chk("x0_ex_pc", ex_pc, 32'h10C);
      chk("x0_ex_rd", ex_rd, 7);

      // lw x5 then rs2=5 but uses_rs2=0 -> no stall
      drive(1, 32'h110, 5'd2, 1, 5'd0, 0, 5'd5, 32'h0, 32'h0, 32'h0, c_lw);
      tick();
      drive(1, 32'h114, 5'd3, 1, 5'd5, 0, 5'd8, 32'h33, 32'h55, 32'h0, c_add);
      chk("nors2_lus", load_use_stall, 0);
      tick();
      chk("nors2_ex_rs2", ex_rs2, 5);
      chk("nors2_ex_pc", ex_pc, 32'h114);

      // flush together with a hazard -> flush wins
      drive(1, 32'h118, 5'd2, 1, 5'd0, 0, 5'd5, 32'h0, 32'h0, 32'h0, c_lw);
      tick();
      drive(1, 32'h11C, 5'd5, 1, 5'd0, 0, 5'd6, 32'h0, 32'h0, 32'h0, c_add);
      ex_flush = 1'b1;
      #1;
      chk("fl_lus", load_use_stall, 0);
      chk("fl_pc_write", pc_write, 1);
      chk("fl_if_id_write", if_id_write, 1);
      tick();
      ex_flush = 1'b0;
      chk("fl_ex_valid", ex_valid, 0);
      chk("fl_ex_ctrl", ex_ctrl, CTRL_NOP);
      chk("fl_flush_cnt", flush_cnt, 1);
      chk("fl_stall_cnt", stall_cnt, 1);

      // mem_stall for 3 cycles with ex_flush asserted -> everything frozen
      drive(1, 32'h120, 5'd1, 1, 5'd2, 1, 5'd9, 32'h77, 32'h88, 32'h0, c_add);
      tick();
      chk("ms_pre_ex_pc", ex_pc, 32'h120);
      drive(1, 32'h124, 5'd3, 1, 5'd4, 1, 5'd10, 32'h1, 32'h2, 32'h3, c_lw);
      mem_stall = 1'b1;
      ex_flush  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("ms_pc_write", pc_write, 0);
         chk("ms_if_id_write", if_id_write, 0);
         chk("ms_lus", load_use_stall, 0);
         tick();
         chk("ms_ex_pc", ex_pc, 32'h120);
         chk("ms_ex_valid", ex_valid, 1);
         chk("ms_ex_rd", ex_rd, 9);
         chk("ms_ex_rdata1", ex_rdata1, 32'h77);
         chk("ms_flush_cnt", flush_cnt, 1);
      end
      mem_stall = 1'b0;
      #1;
      chk("rel_pc_write", pc_write, 1);
      tick();
      ex_flush = 1'b0;
      chk("rel_ex_valid", ex_valid, 0);
      chk("rel_ex_pc", ex_pc, 0);
      chk("rel_flush_cnt", flush_cnt, 2);

      // id_valid=0 is captured as an invalid NOP
      drive(0, 32'h128, 5'd1, 1, 5'd2, 1, 5'd11, 32'h5, 32'h6, 32'h7, c_add);
      tick();
      chk("inv_ex_valid", ex_valid, 0);
      chk("inv_ex_ctrl", ex_ctrl, CTRL_NOP);
      chk("inv_ex_pc", ex_pc, 32'h128);

      // 19 more load-use stalls: counter saturates at 4'hF
      for (int i = 0; i < 19; i++) begin
         drive(1, 32'h200, 5'd2, 1, 5'd0, 0, 5'd5, 32'h0, 32'h0, 32'h0, c_lw);
         tick();
         drive(1, 32'h204, 5'd5, 1, 5'd0, 0, 5'd6, 32'h0, 32'h0, 32'h0, c_add);
         if (i == 0) chk("sat_lus", load_use_stall, 1);
         tick();
         if (i == 0)  chk("sat_cnt_2", stall_cnt, 2);
         if (i == 13) chk("sat_cnt_15", stall_cnt, 15);
      end
      chk("sat_cnt_final", stall_cnt, 4'hF);
      chk("sat_flush_cnt", flush_cnt, 2);

      // Reset mid-operation discards in-flight instruction and counters
      drive(1, 32'h300, 5'd2, 1, 5'd0, 0, 5'd12, 32'h9, 32'h0, 32'h4, c_lw);
      tick();
      chk("mid_ex_valid_pre", ex_valid, 1);
      reset = 1'b1;
      tick();
      chk("mid_ex_valid", ex_valid, 0);
      chk("mid_ex_rd", ex_rd, 0);
      chk("mid_stall_cnt", stall_cnt, 0);
      chk("mid_flush_cnt", flush_cnt, 0);
      reset = 1'b0;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
